ram_access_ctrl: RTL
====================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter: STROBE_CYC, 2, cycles mem_en is held high per beat (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1=write (fill), 0=read.
REQ-007 req_addr  input  4  start address.
REQ-008 req_len  input  4  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-009 req_wdata  input  8  fill data written to every beat of a write burst.
REQ-010 rsp_valid  output  1  response beat available.
REQ-011 rsp_ready  input  1  consumer accepts response beat.
REQ-012 rsp_data  output  8  read data; for writes, the written data.
REQ-013 rsp_last  output  1  marks the final beat of a burst.
REQ-014 mem_en, mem_we  output  1 each  drive the 16x8 asynchronous RAM enable and write enable.
REQ-015 mem_addr  output  4; mem_din  output  8; mem_dout  input  8  RAM address, write data, read data.

Function
REQ-016 FSM states: IDLE, SETUP, STROBE, HOLD, RESP; all outputs are registered.
REQ-017 req_ready = 1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready. On acceptance, latch we, addr, len and wdata, then go to SETUP.
REQ-018 SETUP (1 cycle): mem_addr and mem_din are driven with the beat values; mem_en=0 and mem_we=0. Next state is STROBE.
REQ-019 STROBE (STROBE_CYC cycles): mem_en=1 and mem_we=latched we. Address and data stay stable throughout. On the last STROBE cycle, sample mem_dout into rsp_data for reads, or latched wdata for writes. Next state is HOLD.
REQ-020 HOLD (1 cycle): mem_en=0 and mem_we=0 with address and data unchanged, so we never changes while the address changes. Next state is RESP.
REQ-021 RESP: rsp_valid=1 and rsp_data is stable until rsp_ready. rsp_last=1 on the beat where the beat counter equals len.
REQ-022 On the rsp_valid & rsp_ready cycle:
  - If last: go to IDLE; rsp_valid falls on the next cycle.
  - Otherwise: increment the address modulo 16 (15 wraps to 0), increment the beat counter, and go to SETUP.
REQ-023 Beat latency: accept-to-first rsp_valid = 1 + 1 + STROBE_CYC + 1 cycles (5 with the default). Each subsequent beat takes the same count measured from the previous handshake.
REQ-024 rsp_ready held high continuously: a burst of len+1 beats completes with no extra idle cycles between beats.
REQ-025 rsp_ready low: the FSM stalls in RESP indefinitely with mem_en=0. The RAM is not touched while stalled.
REQ-026 req_valid while busy: the request is ignored (not latched). The requester must hold it until req_ready.
REQ-027 The beat counter is 4 bits. len=15 executes exactly 16 beats, covering every address once.
REQ-028 mem_en and mem_we shall never be high outside STROBE.

Reset
REQ-029 rst_n low immediately forces:
  - State to IDLE.
  - Zeros on req_ready, rsp_valid, rsp_data, rsp_last, mem_en, mem_we, mem_addr, mem_din, and all counters and latches.
REQ-030 req_ready rises on the first clk edge after rst_n deasserts.
REQ-031 Reset during STROBE drops mem_en and mem_we asynchronously. The in-flight burst is discarded with no response.

Verification
REQ-032 Single write: addr=3, wdata=A5, len=0. Required response:
  - mem_we high for exactly 2 cycles, with mem_addr=3 stable from SETUP through HOLD.
  - rsp_data=A5 and rsp_last=1 five cycles after accept.
REQ-033 Readback: write 5A to addr 7, then read addr 7, len=0 -> rsp_data=5A, rsp_last=1.
REQ-034 Wrap burst: fill 3C at addr 14, len=3, then read addr 14, len=3 -> addresses 14,15,0,1 visited. Four beats of 3C, with rsp_last only on the 4th.
REQ-035 Backpressure: rsp_ready held low for 10 cycles on beat 2 of a read burst -> rsp_valid and rsp_data stable, mem_en=0 throughout, and the burst completes correctly after release.
REQ-036 Reset mid-STROBE of a write: rst_n low -> mem_en and mem_we fall within the same cycle, no rsp_valid, and req_ready=1 one edge after release.
REQ-037 Full sweep: fill 00 with len=15, then write distinct values to each address and read back with len=15 -> all 16 values match, with no idle cycles when rsp_ready=1.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Burst controller for a 16x8 asynchronous RAM. Each beat runs as
// setup, enable strobe, hold and then a response handshake.
module ram_access_ctrl #(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_len,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       mem_en,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // SETUP  | address/data presented, RAM disabled
  // STROBE | mem_en high for STROBE_CYC cycles, data sampled on the last one
  // HOLD   | RAM disabled, address/data still stable
  // RESP   | response beat offered until rsp_ready
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  localparam logic [3:0] STRB_LOAD = 4'(STROBE_CYC - 1);

  state_t     state_q, state_d;
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] len_q, len_d;
  logic [3:0] beat_q, beat_d;
  logic [3:0] strb_q, strb_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_last_q, rsp_last_d;
  logic       mem_en_q, mem_en_d;
  logic       mem_we_q, mem_we_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= 4'd0;
      len_q       <= 4'd0;
      beat_q      <= 4'd0;
      strb_q      <= 4'd0;
      wdata_q     <= 8'd0;
      rsp_data_q  <= 8'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          beat_d  = 4'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        strb_d  = STRB_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (strb_q == 4'd0) begin
          rsp_data_d = we_q ? wdata_q : mem_dout;
          state_d    = HOLD;
        end else begin
          strb_d = strb_q - 4'd1;
        end
      end
      HOLD: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 4'd1;
            beat_d  = beat_q + 4'd1;
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies decoded from the next state.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_last_d  = (state_d == RESP) && (beat_d == len_d);
    mem_en_d    = (state_d == STROBE);
    mem_we_d    = (state_d == STROBE) && we_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;

endmodule
